// File: rtl/sitcpxg_tx_arb_pkg.sv
// Shared types and constants for the SiTCP-XG transmit arbiter.
// Header word: magic, channel index, 16-bit burst sequence, zero tail.
package sitcpxg_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HEAD  = 2'd1,
    ST_DATA  = 2'd2,
    ST_CLOSE = 2'd3
  } arb_state_e;

  localparam logic [7:0] HDR_MAGIC_DEF = 8'hA5;

  localparam int HDR_MAGIC_MSB = 63;
  localparam int HDR_MAGIC_LSB = 56;
  localparam int HDR_CH_MSB    = 55;
  localparam int HDR_CH_LSB    = 48;
  localparam int HDR_SEQ_MSB   = 47;
  localparam int HDR_SEQ_LSB   = 32;

  localparam logic [3:0] TX_B_FULL = 4'd8;

  function automatic logic [3:0] clamp_b(input logic [3:0] b);
    return (b > TX_B_FULL) ? TX_B_FULL : b;
  endfunction

  function automatic logic [63:0] make_header(input logic [7:0]  magic,
                                              input logic [7:0]  ch,
                                              input logic [15:0] seq);
    logic [63:0] h;
    h = '0;
    h[HDR_MAGIC_MSB:HDR_MAGIC_LSB] = magic;
    h[HDR_CH_MSB:HDR_CH_LSB]       = ch;
    h[HDR_SEQ_MSB:HDR_SEQ_LSB]     = seq;
    return h;
  endfunction

endpackage

// File: rtl/sitcpxg_rr_pick.sv
// Combinational round-robin picker: first requester after last_idx wins,
// wrapping around so last_idx itself has the lowest priority.
module sitcpxg_rr_pick #(
  parameter int CH_NUM = 4,
  parameter int IDX_W  = 2
) (
  input  logic [CH_NUM-1:0] req,
  input  logic [IDX_W-1:0]  last_idx,
  output logic [CH_NUM-1:0] grant,
  output logic [IDX_W-1:0]  idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 1; off <= CH_NUM; off++) begin
      cand = IDX_W'((int'(last_idx) + off) % CH_NUM);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/sitcpxg_tx_arbiter.sv
// Round-robin multiplexer of CH_NUM user channels onto the SiTCP-XG TX port,
// framing every grant with a header word that tags channel and burst sequence.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | no owner; pick next requester when session up and not afull
//  ST_HEAD  | owner chosen; emit header word once afull is clear
//  ST_DATA  | forward owner payload until LAST or MAX_BURST words
//  ST_CLOSE | close handshake; ack held until close request drops
module sitcpxg_tx_arbiter
  import sitcpxg_tx_arb_pkg::*;
#(
  parameter int         CH_NUM    = 4,
  parameter int         MAX_BURST = 256,
  parameter logic [7:0] HDR_MAGIC = HDR_MAGIC_DEF
) (
  input  logic                 XGMII_CLOCK,
  input  logic                 RSTn,
  input  logic                 USER_SESSION_ESTABLISHED,
  input  logic                 USER_SESSION_CLOSE_REQ,
  output logic                 USER_SESSION_CLOSE_ACK,
  input  logic                 USER_TX_AFULL,
  output logic [63:0]          USER_TX_D,
  output logic [3:0]           USER_TX_B,
  input  logic [CH_NUM-1:0]    CH_VALID,
  input  logic [64*CH_NUM-1:0] CH_D,
  input  logic [4*CH_NUM-1:0]  CH_B,
  input  logic [CH_NUM-1:0]    CH_LAST,
  output logic [CH_NUM-1:0]    CH_READY,
  output logic [CH_NUM-1:0]    CH_GRANT
);

  localparam int          IDX_W      = $clog2(CH_NUM);
  localparam logic [15:0] BEATS_LOAD = 16'(MAX_BURST - 1);

  arb_state_e        state;
  logic [CH_NUM-1:0] grant;
  logic [IDX_W-1:0]  gidx;
  logic [IDX_W-1:0]  last_idx;
  logic [15:0]       beats_left;
  logic [15:0]       seq [CH_NUM];
  logic [63:0]       tx_d;
  logic [3:0]        tx_b;
  logic              close_ack;

  logic [CH_NUM-1:0] pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic [63:0]       sel_d;
  logic [3:0]        sel_b;
  logic              sel_last;
  logic              sel_valid;
  logic              ready_any;
  logic              accept;
  logic              hdr_fire;
  logic              burst_end;

  sitcpxg_rr_pick #(
    .CH_NUM (CH_NUM),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req      (CH_VALID),
    .last_idx (last_idx),
    .grant    (pick_grant),
    .idx      (pick_idx)
  );

  // Owner mux driven by the one-hot grant.
  always_comb begin
    sel_d     = '0;
    sel_b     = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (grant[i]) begin
        sel_d     = CH_D[64*i +: 64];
        sel_b     = CH_B[4*i +: 4];
        sel_last  = CH_LAST[i];
        sel_valid = CH_VALID[i];
      end
    end
  end

  // Session-down also blocks READY so no word is taken and then dropped.
  assign ready_any = (state == ST_DATA) & ~USER_TX_AFULL & ~USER_SESSION_CLOSE_REQ
                     & USER_SESSION_ESTABLISHED;
  assign accept    = ready_any & sel_valid;
  assign hdr_fire  = (state == ST_HEAD) & ~USER_TX_AFULL & ~USER_SESSION_CLOSE_REQ
                     & USER_SESSION_ESTABLISHED;
  assign burst_end = accept & (sel_last | (beats_left == '0));

  assign CH_READY               = grant & {CH_NUM{ready_any}};
  assign CH_GRANT               = grant;
  assign USER_TX_D              = tx_d;
  assign USER_TX_B              = tx_b;
  assign USER_SESSION_CLOSE_ACK = close_ack;

  always_ff @(posedge XGMII_CLOCK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < CH_NUM; i++) seq[i] <= '0;
    end else if (!USER_SESSION_ESTABLISHED) begin
      for (int i = 0; i < CH_NUM; i++) seq[i] <= '0;
    end else if (hdr_fire) begin
      seq[gidx] <= seq[gidx] + 16'd1;
    end
  end

  always_ff @(posedge XGMII_CLOCK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= ST_IDLE;
      grant      <= '0;
      gidx       <= '0;
      last_idx   <= IDX_W'(CH_NUM - 1);
      beats_left <= '0;
      tx_d       <= '0;
      tx_b       <= '0;
      close_ack  <= 1'b0;
    end else begin
      tx_b <= '0;
      case (state)
        ST_IDLE: begin
          if (USER_SESSION_CLOSE_REQ) begin
            state     <= ST_CLOSE;
            close_ack <= 1'b1;
          end else if (USER_SESSION_ESTABLISHED && !USER_TX_AFULL && |CH_VALID) begin
            state    <= ST_HEAD;
            grant    <= pick_grant;
            gidx     <= pick_idx;
            last_idx <= pick_idx;
          end
        end
        ST_HEAD: begin
          if (USER_SESSION_CLOSE_REQ) begin
            state     <= ST_CLOSE;
            close_ack <= 1'b1;
            grant     <= '0;
          end else if (!USER_SESSION_ESTABLISHED) begin
            state <= ST_IDLE;
            grant <= '0;
          end else if (!USER_TX_AFULL) begin
            tx_d       <= make_header(HDR_MAGIC, 8'(gidx), seq[gidx]);
            tx_b       <= TX_B_FULL;
            beats_left <= BEATS_LOAD;
            state      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (USER_SESSION_CLOSE_REQ) begin
            state     <= ST_CLOSE;
            close_ack <= 1'b1;
            grant     <= '0;
          end else if (!USER_SESSION_ESTABLISHED) begin
            state <= ST_IDLE;
            grant <= '0;
          end else if (accept) begin
            if (sel_b != '0) begin
              tx_d <= sel_d;
              tx_b <= clamp_b(sel_b);
            end
            if (burst_end) begin
              state <= ST_IDLE;
              grant <= '0;
            end else begin
              beats_left <= beats_left - 16'd1;
            end
          end
        end
        ST_CLOSE: begin
          if (!USER_SESSION_CLOSE_REQ) begin
            state     <= ST_IDLE;
            close_ack <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
